// File: rtl/anim_frame_timer_pkg.sv
// Shared types and default constants for the animation frame timer.
package anim_frame_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_PRE_W      = 20;
  localparam int unsigned DEF_FRM_W      = 4;
  localparam int unsigned DEF_PERIOD_VAL = 128;
  localparam int unsigned DEF_FRAMES_VAL = 15;

endpackage

// File: rtl/reload_down_counter.sv
// Down-counter that reloads on request or when it expires while enabled.
module reload_down_counter #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         reload,
  input  logic [W-1:0] reload_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Explicit reload wins; an enabled expiry reloads instead of underflowing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= RST_VAL;
    end else if (reload) begin
      count <= reload_val;
    end else if (en) begin
      if (zero) begin
        count <= reload_val;
      end else begin
        count <= count - W'(1);
      end
    end else begin
      count <= count;
    end
  end

  // Zero flag is decoded from the registered count only.
  always_comb begin
    zero = (count == {W{1'b0}});
  end

endmodule

// File: rtl/anim_frame_timer.sv
// Animation timing generator: prescaler tick, frame countdown and control FSM.
module anim_frame_timer
  import anim_frame_timer_pkg::*;
#(
  parameter int unsigned PRE_W      = DEF_PRE_W,
  parameter int unsigned FRM_W      = DEF_FRM_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_VAL,
  parameter int unsigned DEF_FRAMES = DEF_FRAMES_VAL
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             load,
  input  logic [PRE_W-1:0] period_in,
  input  logic [FRM_W-1:0] frames_in,
  input  logic             oneshot,
  output logic             tick,
  output logic [FRM_W-1:0] frame,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  state_t             state;
  logic [PRE_W-1:0]   period_reg;
  logic [FRM_W-1:0]   frames_reg;
  logic               mode_reg;

  logic               start_go;
  logic               finish;
  logic               pre_en;
  logic               pre_reload;
  logic [PRE_W-1:0]   pre_val;
  logic [PRE_W-1:0]   pre_cnt;
  logic               pre_zero;
  logic               frm_en;
  logic               frm_reload;
  logic [FRM_W-1:0]   frm_val;
  logic               frm_zero;

  // Counter controls; load coincident with start feeds the new values straight in.
  always_comb begin
    start_go   = start & ~stop & ((state == ST_IDLE) | (state == ST_DONE));
    tick       = (state == ST_RUN) & pre_zero;
    wrap       = tick & frm_zero;
    finish     = wrap & mode_reg;
    pre_en     = (state == ST_RUN) & ~stop;
    pre_reload = stop | start_go;
    frm_en     = tick & ~finish & ~stop;
    frm_reload = stop | start_go;
    if (start_go && load) begin
      pre_val = period_in;
      frm_val = frames_in;
    end else begin
      pre_val = period_reg;
      frm_val = frames_reg;
    end
    done = (state == ST_DONE);
    busy = (state == ST_RUN) | (state == ST_PAUSE);
  end

  reload_down_counter #(
    .W       (PRE_W),
    .RST_VAL (PRE_W'(DEF_PERIOD))
  ) u_pre (
    .clk        (clk),
    .resetn     (resetn),
    .en         (pre_en),
    .reload     (pre_reload),
    .reload_val (pre_val),
    .count      (pre_cnt),
    .zero       (pre_zero)
  );

  // A oneshot finish leaves the frame counter parked at zero.
  reload_down_counter #(
    .W       (FRM_W),
    .RST_VAL (FRM_W'(DEF_FRAMES))
  ) u_frm (
    .clk        (clk),
    .resetn     (resetn),
    .en         (frm_en),
    .reload     (frm_reload),
    .reload_val (frm_val),
    .count      (frame),
    .zero       (frm_zero)
  );

  // Control FSM with shadow reload registers and the latched run mode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      period_reg <= PRE_W'(DEF_PERIOD);
      frames_reg <= FRM_W'(DEF_FRAMES);
      mode_reg   <= 1'b0;
    end else begin
      if (load) begin
        period_reg <= period_in;
        frames_reg <= frames_in;
      end else begin
        period_reg <= period_reg;
        frames_reg <= frames_reg;
      end

      if (start_go) begin
        mode_reg <= oneshot;
      end else begin
        mode_reg <= mode_reg;
      end

      if (stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  state <= start ? ST_RUN : ST_IDLE;
          ST_DONE:  state <= start ? ST_RUN : ST_DONE;
          ST_RUN: begin
            if (finish) begin
              state <= ST_DONE;
            end else if (pause) begin
              state <= ST_PAUSE;
            end else begin
              state <= ST_RUN;
            end
          end
          ST_PAUSE: state <= pause ? ST_PAUSE : ST_RUN;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
